// File: rtl/thr_monitor.sv
// Threshold monitor: registered sample-vs-threshold compare, run/alarm FSM, sample statistics (min/max under THR_MONITOR_MINMAX_EN).
// Latency: compare flags, run_cnt, alarm and statistics reflect a sample one cycle after it is presented.
// Backpressure: none, always ready; a sample presented together with clr is dropped.
module thr_monitor #(
    parameter int ALARM_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       thr_load,
    input  logic [3:0] thr_data,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       out_valid,
    output logic       eq,
    output logic       lt,
    output logic       gt,
    output logic       alarm,
    output logic [2:0] run_cnt,
    output logic [3:0] min_val,
    output logic [3:0] max_val,
    output logic [7:0] sample_cnt
);

    localparam logic [2:0] ALEN = 3'(ALARM_LEN);

    typedef enum logic [1:0] {IDLE, TRACK, ALARM} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] thr;
    logic       accept;
    logic       s_gt;
    logic       s_lt;
    logic [2:0] run_nxt;

    assign accept = in_valid & ~clr;
    // Compare uses the threshold held before any same-cycle thr_load.
    assign s_gt   = in_data > thr;
    assign s_lt   = in_data < thr;
    assign alarm  = (state == ALARM);

    always_comb begin
        run_nxt = run_cnt;
        if (accept) begin
            if (!s_gt) begin
                run_nxt = 3'd0;
            end else if (run_cnt != ALEN) begin
                run_nxt = run_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (accept) begin
            case (state)
                IDLE, TRACK: state_nxt = (run_nxt == ALEN) ? ALARM : TRACK;
                // Equal samples keep the alarm up; only a below-threshold sample drops it.
                ALARM:       if (s_lt) state_nxt = TRACK;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr        <= 4'd0;
            out_valid  <= 1'b0;
            eq         <= 1'b0;
            lt         <= 1'b0;
            gt         <= 1'b0;
            run_cnt    <= 3'd0;
            sample_cnt <= 8'd0;
        end else begin
            if (thr_load) begin
                thr <= thr_data;
            end
            out_valid <= accept;
            if (accept) begin
                eq <= ~s_gt & ~s_lt;
                lt <= s_lt;
                gt <= s_gt;
            end
            run_cnt <= clr ? 3'd0 : run_nxt;
            if (clr) begin
                sample_cnt <= 8'd0;
            end else if (accept && sample_cnt != 8'hFF) begin
                sample_cnt <= sample_cnt + 8'd1;
            end
        end
    end

`ifdef THR_MONITOR_MINMAX_EN
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            min_val <= 4'd0;
            max_val <= 4'd0;
        end else if (accept) begin
            // First sample after reset/clr seeds both extremes.
            if (state == IDLE || in_data < min_val) begin
                min_val <= in_data;
            end
            if (state == IDLE || in_data > max_val) begin
                max_val <= in_data;
            end
        end
    end
`else
    assign min_val = 4'd0;
    assign max_val = 4'd0;
`endif

endmodule

// File: doc/thr_monitor.md
THR_MONITOR -- requirements
Module: thr_monitor

Interface
REQ-001 SHALL have parameter ALARM_LEN, default 3, number of consecutive above-threshold samples (legal 1..7) that raises the alarm.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port clr  input  1  soft clear of tracking state; threshold is kept.
REQ-005 SHALL have port thr_load  input  1  load thr_data into the threshold register.
REQ-006 SHALL have port thr_data  input  4  new unsigned threshold.
REQ-007 SHALL have port in_valid  input  1  in_data holds a sample this cycle; the block is always ready.
REQ-008 SHALL have port in_data  input  4  unsigned sample.
REQ-009 SHALL have port out_valid  output  1  eq/lt/gt hold the result for the previous cycle's sample.
REQ-010 SHALL have ports eq, lt, gt  output  1 each  registered compare of sample vs threshold.
REQ-011 SHALL have port alarm  output  1  high while FSM is in ALARM.
REQ-012 SHALL have port run_cnt  output  3  current consecutive above-threshold count.
REQ-013 SHALL have ports min_val, max_val  output  4 each  smallest and largest sample since reset/clr.
REQ-014 SHALL have port sample_cnt  output  8  accepted samples since reset/clr.

Function
REQ-015 SHALL compare in_data with threshold unsigned; exactly one of eq/lt/gt high whenever out_valid=1.
REQ-016 SHALL register the compare with 1-cycle latency: sample at edge N, out_valid and flags valid after edge N+1; out_valid=0 otherwise, and eq/lt/gt hold their last values.
REQ-017 SHALL, on thr_load with in_valid in the same cycle, compare that sample against the old threshold; the new threshold applies from the next cycle.
REQ-018 SHALL implement FSM states IDLE (no sample since reset/clr), TRACK and ALARM.
REQ-019 SHALL go IDLE->TRACK on the first accepted sample, or IDLE->ALARM if ALARM_LEN=1 and that sample is gt.
REQ-020 SHALL increment run_cnt on each gt sample, saturating at ALARM_LEN, and zero run_cnt on each eq or lt sample; cycles with in_valid=0 SHALL not affect run_cnt.
REQ-021 SHALL go TRACK->ALARM on the sample that brings run_cnt to ALARM_LEN; alarm is high from the following cycle.
REQ-022 SHALL keep ALARM on eq samples (hysteresis) and go ALARM->TRACK only on an lt sample.
REQ-023 SHALL load both min_val and max_val from the first sample in IDLE, then update each only on strict less-than or greater-than.
REQ-024 SHALL increment sample_cnt on each accepted sample, saturating at 255.
REQ-025 SHALL, on clr, enter IDLE and zero run_cnt, sample_cnt, min_val, max_val, alarm and out_valid next cycle; clr SHALL override in_valid in the same cycle, and that sample is dropped.

Reset
REQ-026 SHALL on rst=1 at a clock edge set FSM=IDLE, threshold=0, all outputs=0; rst SHALL override clr, thr_load and in_valid, including mid-run in ALARM.

Configuration
REQ-027 SHALL compile min/max tracking only when macro THR_MONITOR_MINMAX_EN is defined; without it min_val and max_val SHALL be constant 0, with no min/max registers, and all other behaviour SHALL be unchanged.

Verification
REQ-028 SHALL check thr=5, samples 4,5,6 -> out_valid pulses, flags lt, eq, gt each one cycle after its sample.
REQ-029 SHALL check ALARM_LEN=3, thr=5, samples 9,9,idle cycle,9 -> run_cnt 1,2,2,3; alarm rises the cycle after the third 9.
REQ-030 SHALL check in ALARM, samples 5 then 2 -> alarm stays high after 5 and falls the cycle after 2; run_cnt=0.
REQ-031 SHALL check thr_load(thr_data=3) with in_valid(in_data=4) while thr=7 -> lt reported; then sample 4 -> gt.
REQ-032 SHALL check samples 7,2,12 then clr with in_valid(in_data=1) -> min=2/max=12 before clr; after clr all zero, IDLE, sample_cnt=0; next sample 6 -> min=max=6.
REQ-033 SHALL check 300 samples -> sample_cnt saturates at 255; then rst during ALARM -> all outputs 0 and threshold 0 the next cycle.
